// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the M-extension sequencer: operation codes, FSM states
// and divider iteration count.
package muldiv_sequencer_pkg;

  localparam int DIV_ITERATIONS = 32;

  localparam logic [5:0] ALU_OPERATIONS_ADD   = 6'h00;
  localparam logic [5:0] ALU_OPERATIONS_MUL   = 6'h20;
  localparam logic [5:0] ALU_OPERATIONS_MULH  = 6'h21;
  localparam logic [5:0] ALU_OPERATIONS_MULSU = 6'h22;
  localparam logic [5:0] ALU_OPERATIONS_MULU  = 6'h23;
  localparam logic [5:0] ALU_OPERATIONS_DIV   = 6'h24;
  localparam logic [5:0] ALU_OPERATIONS_DIVU  = 6'h25;
  localparam logic [5:0] ALU_OPERATIONS_REM   = 6'h26;
  localparam logic [5:0] ALU_OPERATIONS_REMU  = 6'h27;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL   = 3'd1,
    DIV   = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } muldiv_state_t;

  function automatic logic is_muldiv_op(input logic [5:0] op);
    return op inside {ALU_OPERATIONS_MUL, ALU_OPERATIONS_MULH, ALU_OPERATIONS_MULSU,
                      ALU_OPERATIONS_MULU, ALU_OPERATIONS_DIV, ALU_OPERATIONS_DIVU,
                      ALU_OPERATIONS_REM, ALU_OPERATIONS_REMU};
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract the
// divisor when it does not borrow, and shift the new quotient bit in.
module muldiv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quotient,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_next,
  output logic [XLEN-1:0] quotient_next
);

  logic [XLEN+1:0] rem_shifted;
  logic [XLEN+1:0] diff;
  logic            borrow;

  // The quotient register doubles as the dividend shifter, so its MSB is the next dividend bit.
  assign rem_shifted   = {rem, quotient[XLEN-1]};
  assign diff          = rem_shifted - {2'b00, divisor};
  assign borrow        = diff[XLEN+1];
  assign rem_next      = borrow ? rem_shifted[XLEN:0] : diff[XLEN:0];
  assign quotient_next = {quotient[XLEN-2:0], ~borrow};

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/DIV controller for the execute stage; stalls upstream until the
// result is returned.
//
// state | meaning
// IDLE  | ready, waiting for an M-extension op
// MUL   | latched operands, product computed and captured into result
// DIV   | 32 restoring iterations, one quotient bit per cycle
// FIXUP | apply sign to quotient / remainder
// DONE  | result_valid pulse, back to IDLE
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid,
  input  logic [5:0]      alu_operation,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic            flush,
  output logic            ready,
  output logic            stall,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  muldiv_state_t   state, state_next;
  logic [5:0]      op_q;
  logic [XLEN:0]   mul_a_q, mul_b_q;
  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] quo_q, divisor_q;
  logic [4:0]      count_q;
  logic            neg_quo_q, neg_rem_q;
  logic [XLEN-1:0] result_q;

  logic            accept;
  logic            op_is_mul, op_signed_div, op_is_rem;
  logic            mul_a_signed, mul_b_signed;
  logic            div_by_zero, div_overflow, special;
  logic [XLEN-1:0] special_result;
  logic            dvd_neg, dvs_neg;
  logic [XLEN-1:0] dvd_mag, dvs_mag;

  logic [XLEN:0]     step_rem;
  logic [XLEN-1:0]   step_quo;
  logic [2*XLEN-1:0] mul_a_wide, mul_b_wide, product;
  logic [XLEN-1:0]   mul_result, quo_fix, rem_fix, fix_result;
  logic [XLEN-1:0]   result_d;
  logic              load_result;

  // Decode of the incoming request; only meaningful in the accept cycle.
  always_comb begin
    accept        = valid && (state == IDLE) && is_muldiv_op(alu_operation) && !flush;
    op_is_mul     = alu_operation inside {ALU_OPERATIONS_MUL, ALU_OPERATIONS_MULH,
                                          ALU_OPERATIONS_MULSU, ALU_OPERATIONS_MULU};
    op_signed_div = (alu_operation == ALU_OPERATIONS_DIV) || (alu_operation == ALU_OPERATIONS_REM);
    op_is_rem     = (alu_operation == ALU_OPERATIONS_REM) || (alu_operation == ALU_OPERATIONS_REMU);
    mul_a_signed  = (alu_operation == ALU_OPERATIONS_MULH) || (alu_operation == ALU_OPERATIONS_MULSU);
    mul_b_signed  = (alu_operation == ALU_OPERATIONS_MULH);
    div_by_zero   = (operand2 == '0);
    div_overflow  = op_signed_div && (operand1 == {1'b1, {(XLEN-1){1'b0}}}) && (operand2 == '1);
    special       = !op_is_mul && (div_by_zero || div_overflow);
    if (div_by_zero) special_result = op_is_rem ? operand1 : '1;
    else             special_result = op_is_rem ? '0 : operand1;
    dvd_neg = op_signed_div && operand1[XLEN-1];
    dvs_neg = op_signed_div && operand2[XLEN-1];
    dvd_mag = dvd_neg ? -operand1 : operand1;
    dvs_mag = dvs_neg ? -operand2 : operand2;
  end

  muldiv_div_step #(.XLEN(XLEN)) u_div_step (
    .rem           (rem_q),
    .quotient      (quo_q),
    .divisor       (divisor_q),
    .rem_next      (step_rem),
    .quotient_next (step_quo)
  );

  // Low 2*XLEN bits of the 33x33 signed product; sign-extending makes a plain multiply exact.
  always_comb begin
    mul_a_wide = {{(XLEN-1){mul_a_q[XLEN]}}, mul_a_q};
    mul_b_wide = {{(XLEN-1){mul_b_q[XLEN]}}, mul_b_q};
    product    = mul_a_wide * mul_b_wide;
    mul_result = (op_q == ALU_OPERATIONS_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
    quo_fix    = neg_quo_q ? -quo_q : quo_q;
    rem_fix    = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    fix_result = ((op_q == ALU_OPERATIONS_REM) || (op_q == ALU_OPERATIONS_REMU)) ? rem_fix : quo_fix;
  end

  always_comb begin
    state_next = state;
    result_d   = '0;
    case (state)
      IDLE: begin
        result_d = special_result;
        if (accept) begin
          if (op_is_mul)    state_next = MUL;
          else if (special) state_next = DONE;
          else              state_next = DIV;
        end
      end
      MUL: begin
        result_d   = mul_result;
        state_next = DONE;
      end
      DIV: begin
        if (count_q == 5'(DIV_ITERATIONS - 1)) state_next = FIXUP;
      end
      FIXUP: begin
        result_d   = fix_result;
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush && (state != IDLE)) state_next = IDLE;
    load_result = (state_next == DONE) && (state != DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      count_q   <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_q      <= alu_operation;
        mul_a_q   <= {mul_a_signed & operand1[XLEN-1], operand1};
        mul_b_q   <= {mul_b_signed & operand2[XLEN-1], operand2};
        rem_q     <= '0;
        quo_q     <= dvd_mag;
        divisor_q <= dvs_mag;
        count_q   <= '0;
        neg_quo_q <= dvd_neg ^ dvs_neg;
        neg_rem_q <= dvd_neg;
      end else if (state == DIV) begin
        rem_q <= step_rem;
        quo_q <= step_quo;
        if (count_q != 5'(DIV_ITERATIONS - 1)) count_q <= count_q + 5'd1;
      end
      if (load_result) result_q <= result_d;
    end
  end

  assign ready        = (state == IDLE);
  assign stall        = accept || (state inside {MUL, DIV, FIXUP});
  assign result_valid = (state == DONE) && !flush;
  assign result       = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer with hand-computed results and latencies.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic        clk, rst_n, valid, flush;
  logic [5:0]  alu_operation;
  logic [31:0] operand1, operand2;
  logic        ready, stall, result_valid;
  logic [31:0] result;

  int n_vec = 0;
  int n_err = 0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid         (valid),
    .alu_operation (alu_operation),
    .operand1      (operand1),
    .operand2      (operand2),
    .flush         (flush),
    .ready         (ready),
    .stall         (stall),
    .result_valid  (result_valid),
    .result        (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op in cycle 0, scramble the inputs afterwards, and check the result
  // value, the cycle of the pulse and that the pulse lasts exactly one cycle.
  task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    lat = -1;
    @(posedge clk); #1;
    valid = 1'b1; alu_operation = op; operand1 = a; operand2 = b;
    @(negedge clk);
    chk({tag, "_stall_c0"}, 32'(stall), 32'd1);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      valid = 1'b0; operand1 = ~a; operand2 = ~b; alu_operation = ALU_OPERATIONS_DIVU;
      @(negedge clk);
      if (result_valid) begin
        lat = c;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, result, exp);
    @(negedge clk);
    chk({tag, "_pulse_end"}, 32'(result_valid), 32'd0);
  endtask

  logic [31:0] held;

  initial begin
    rst_n = 1'b0; valid = 1'b0; flush = 1'b0;
    alu_operation = ALU_OPERATIONS_ADD; operand1 = '0; operand2 = '0;
    #3;
    chk("rst_result", result, 32'd0);
    chk("rst_rvalid", 32'(result_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    #9 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);

    // MUL with per-cycle handshake checks
    @(posedge clk); #1;
    valid = 1'b1; alu_operation = ALU_OPERATIONS_MUL; operand1 = 32'd7; operand2 = 32'hFFFF_FFFD;
    @(negedge clk);
    chk("mul_c0_stall", 32'(stall), 32'd1);
    chk("mul_c0_rv", 32'(result_valid), 32'd0);
    @(posedge clk); #1;
    valid = 1'b0; operand1 = 32'h1234_5678; operand2 = 32'h9;
    @(negedge clk);
    chk("mul_c1_stall", 32'(stall), 32'd1);
    chk("mul_c1_ready", 32'(ready), 32'd0);
    chk("mul_c1_rv", 32'(result_valid), 32'd0);
    @(negedge clk);
    chk("mul_c2_rv", 32'(result_valid), 32'd1);
    chk("mul_c2_res", result, 32'hFFFF_FFEB);
    chk("mul_c2_stall", 32'(stall), 32'd0);
    chk("mul_c2_ready", 32'(ready), 32'd0);
    @(negedge clk);
    chk("mul_c3_rv", 32'(result_valid), 32'd0);
    chk("mul_c3_ready", 32'(ready), 32'd1);

    run_op("mulh",  ALU_OPERATIONS_MULH,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
    run_op("mulu",  ALU_OPERATIONS_MULU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    run_op("mulsu", ALU_OPERATIONS_MULSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    run_op("mul_lo", ALU_OPERATIONS_MUL,  32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 2);
    run_op("div",   ALU_OPERATIONS_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("rem",   ALU_OPERATIONS_REM,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("divu",  ALU_OPERATIONS_DIVU,  32'd100, 32'd7, 32'd14, 34);
    run_op("remu",  ALU_OPERATIONS_REMU,  32'd100, 32'd7, 32'd2, 34);
    run_op("div_neg_dvs", ALU_OPERATIONS_DIV, 32'd20, 32'hFFFF_FFFA, 32'hFFFF_FFFD, 34);
    run_op("rem_neg_dvs", ALU_OPERATIONS_REM, 32'd20, 32'hFFFF_FFFA, 32'd2, 34);
    run_op("divu_big", ALU_OPERATIONS_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 34);
    run_op("div0",  ALU_OPERATIONS_DIV,   32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu0", ALU_OPERATIONS_REMU,  32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf", ALU_OPERATIONS_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", ALU_OPERATIONS_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Flush in cycle 10 of a divide, then a MUL accepted in cycle 11
    held = result;
    @(posedge clk); #1;
    valid = 1'b1; alu_operation = ALU_OPERATIONS_DIVU; operand1 = 32'd100; operand2 = 32'd7;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      valid = 1'b0;
      if (c == 10) flush = 1'b1;
      @(negedge clk);
      if (c == 10) begin
        chk("flush_c10_rv", 32'(result_valid), 32'd0);
        chk("flush_c10_stall", 32'(stall), 32'd1);
      end
    end
    @(posedge clk); #1;
    flush = 1'b0;
    valid = 1'b1; alu_operation = ALU_OPERATIONS_MUL; operand1 = 32'd3; operand2 = 32'd5;
    @(negedge clk);
    chk("flush_c11_ready", 32'(ready), 32'd1);
    chk("flush_c11_res", result, held);
    chk("flush_c11_rv", 32'(result_valid), 32'd0);
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    chk("flush_c12_rv", 32'(result_valid), 32'd0);
    chk("flush_c12_res", result, held);
    @(negedge clk);
    chk("flush_c13_rv", 32'(result_valid), 32'd1);
    chk("flush_c13_res", result, 32'd15);

    // Non-M code is ignored
    @(posedge clk); #1;
    @(posedge clk); #1;
    valid = 1'b1; alu_operation = ALU_OPERATIONS_ADD; operand1 = 32'd1; operand2 = 32'd2;
    @(negedge clk);
    chk("add_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    chk("add_ready", 32'(ready), 32'd1);
    chk("add_res", result, 32'd15);

    // Asynchronous reset in cycle 5 of a divide
    @(posedge clk); #1;
    valid = 1'b1; alu_operation = ALU_OPERATIONS_DIVU; operand1 = 32'd100; operand2 = 32'd7;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      valid = 1'b0;
    end
    chk("arst_pre_stall", 32'(stall), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_result", result, 32'd0);
    chk("arst_rv", 32'(result_valid), 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (result_valid) break;
    end
    chk("arst_no_result", 32'(result_valid), 32'd0);
    chk("arst_ready", 32'(ready), 32'd1);

    run_op("post_rst_divu", ALU_OPERATIONS_DIVU, 32'd1000, 32'd33, 32'd30, 34);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller for the M-extension operations in the execute stage.
- Accepts one MUL/MULH/MULSU/MULU/DIV/DIVU/REM/REMU request at a time and runs it through a registered multiplier or a 32-iteration restoring divider.
- Applies RISC-V sign and corner-case rules.
- Raises a stall to the hazard logic until the result is returned, so the single-cycle ALU no longer carries the M-extension paths.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported and verified.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- valid  in  1  execute stage presents an operation this cycle
- alu_operation  in  6  operation code; `ALU_OPERATIONS_* encoding
- operand1  in  XLEN  rs1 value (multiplicand/dividend)
- operand2  in  XLEN  rs2 value (multiplier/divisor)
- flush  in  1  synchronous kill of the in-flight operation (branch/jump redirect)
- ready  out  1  idle, can accept
- stall  out  1  hold upstream stages
- result_valid  out  1  one-cycle pulse, result is final
- result  out  XLEN  result; held until next acceptance

Behaviour:
- States: IDLE, MUL, DIV, FIXUP, DONE.
- Reset (async, rst_n=0): state=IDLE, result=0, result_valid=0, ready=1 after release, stall=0; all internal registers (counter, remainder, quotient, sign flags) cleared. Reset mid-operation aborts with no result.
- Accept: cycle 0 = valid && ready && op is one of the eight M codes. Any other code is ignored; state stays IDLE and stall=0.
- ready = (state==IDLE).
- stall = accept condition in IDLE, or state in {MUL, DIV, FIXUP}. stall=0 in DONE.
- MUL path:
  - IDLE->MUL: operands latched with sign flags.
  - MUL: 33x33 signed product of sign/zero-extended operands, registered.
  - MUL->DONE. result_valid in cycle 2.
  - MUL returns product[31:0]. MULH returns signed x signed [63:32]. MULSU returns signed rs1 x unsigned rs2 [63:32]. MULU returns unsigned x unsigned [63:32].
- DIV path (normal):
  - IDLE->DIV: magnitudes latched for signed ops, count=0.
  - DIV: 32 cycles, one quotient bit per cycle, MSB first. remainder=(rem<<1)|next dividend bit; subtract the divisor if no borrow.
  - DIV->FIXUP when count==31.
  - FIXUP: quotient negated if signs differ (DIV); remainder takes the dividend sign (REM).
  - FIXUP->DONE. result_valid in cycle 34.
- DIV special cases, decided at acceptance; IDLE->DONE directly, result_valid in cycle 1:
  - divisor==0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> operand1.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: DIV -> 0x80000000; REM -> 0.
- DONE: result_valid=1 for exactly one cycle; DONE->IDLE. No acceptance in DONE, so back-to-back ops have a one-cycle bubble.
- result register is written on entry to DONE only.
- Flush:
  - Any non-IDLE state -> IDLE next cycle. result not updated.
  - result_valid is forced 0 in a cycle where flush=1.
  - Flush has priority over acceptance in the same cycle (nothing accepted).
- Operands are sampled only at acceptance; later changes on operand1/operand2/alu_operation are ignored.
- Arithmetic is modulo 2^XLEN. Divider working remainder is XLEN+1 bits for the borrow. Iteration counter is 5 bits, no wrap past 31.

Decomposition:
- The eight `ALU_OPERATIONS_* M codes stay in the shared isa.svh.
- Add a state enum typedef (muldiv_state_t) and a DIV_ITERATIONS=32 constant to the shared ISA package/header.
- One sub-module: muldiv_div_step, the combinational single restoring-divide iteration (inputs rem, quotient, divisor; outputs next rem, next quotient). The state machine, multiplier register and sign fixup stay in muldiv_sequencer.

Test Plan:
- MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, result_valid cycle 2 only, stall=1 cycles 0-1, ready=0 cycles 1-2.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF, result_valid cycle 34; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0. All with result_valid in cycle 1.
- DIV running, flush=1 in cycle 10 -> IDLE/ready=1 in cycle 11, no result_valid, result unchanged. MUL accepted in cycle 11 gives a correct result in cycle 13.
- rst_n=0 asynchronously in cycle 5 of DIV -> outputs 0 immediately. Valid ADD code in IDLE -> no accept, stall=0.
